// File: rtl/snn_pkg.sv
// Shared definitions for the spiking classifier.
//   - state_e : readout FSM states
//   - clog2   : ceiling log2 helper for parameter-derived widths
//   - SNN_TSTEPS / SNN_OUTPUTS : default window length and class count,
//     kept in one place so the network top and readout agree.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    localparam int SNN_TSTEPS  = 20;
    localparam int SNN_OUTPUTS = 2;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 30; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spike_counter.sv
// Single saturating spike counter.
// Ports:
//   clk, rstb : clock, asynchronous active-low reset
//   clr_i     : synchronous clear (wins over inc_i)
//   inc_i     : count one spike this edge
//   cnt_o     : current count, sticks at 2**CNT_W-1
module spike_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_readout.sv
// Output-layer readout: counts spikes per output neuron over a window of
// TSTEPS cycles, then picks the winner with a sequential argmax and holds
// the result behind a valid/ready handshake.
// Ports:
//   clk, rstb   : clock, asynchronous active-low reset
//   start_i     : start a window (only honoured in IDLE)
//   spikes_i    : one spike bit per output neuron
//   re_o        : inhibit/reset pulse to the neurons during CLEAR
//   busy_o      : not IDLE
//   valid_o     : result available (HOLD)
//   ready_i     : consumer accepts the result
//   class_o     : winning neuron index (lowest index on a tie)
//   tie_o       : another neuron matched the winning count
//   none_o      : no spikes at all in the window
//   counts_o    : raw final counts, only when SPIKE_READOUT_COUNTS_EN is defined
module spike_readout
    import snn_pkg::*;
#(
    parameter int OUTPUTS = SNN_OUTPUTS,
    parameter int TSTEPS  = SNN_TSTEPS,
    parameter int CNT_W   = 5,
    parameter int CLS_W   = 1
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start_i,
    input  logic [OUTPUTS-1:0] spikes_i,
    output logic               re_o,
    output logic               busy_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [CLS_W-1:0]   class_o,
    output logic               tie_o,
    output logic               none_o
`ifdef SPIKE_READOUT_COUNTS_EN
    ,
    output logic [OUTPUTS*CNT_W-1:0] counts_o
`endif
);

    localparam int TS_W = clog2(TSTEPS + 1);

    state_e             state_d, state_q;
    logic [TS_W-1:0]    tstep_d, tstep_q;
    logic [CLS_W-1:0]   idx_d, idx_q;
    logic [CNT_W-1:0]   best_d, best_q;
    logic [CLS_W-1:0]   best_idx_d, best_idx_q;
    logic               tie_run_d, tie_run_q;
    logic [CLS_W-1:0]   class_d, class_q;
    logic               tie_d, tie_q;
    logic               none_d, none_q;
    logic               re_d, re_q;
    logic               busy_d, busy_q;
    logic               valid_d, valid_q;

    logic               clr_s;
    logic [OUTPUTS-1:0] inc_s;
    logic [CNT_W-1:0]   cnt_s [OUTPUTS];
    logic [CNT_W-1:0]   cur_cnt_s;
    logic [CNT_W-1:0]   nb_s;
    logic [CLS_W-1:0]   nbi_s;
    logic               nt_s;

    for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_cnt
        spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rstb  (rstb),
            .clr_i (clr_s),
            .inc_i (inc_s[gi]),
            .cnt_o (cnt_s[gi])
        );
    end

    // Counters clear on the accepting start edge and only count in COUNT.
    always_comb begin
        clr_s = (state_q == ST_IDLE) && start_i;
        if (state_q == ST_COUNT) begin
            inc_s = spikes_i;
        end else begin
            inc_s = '0;
        end
    end

    // Next-state, argmax step and registered-output next values.
    always_comb begin
        state_d    = state_q;
        tstep_d    = tstep_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        tie_run_d  = tie_run_q;
        class_d    = class_q;
        tie_d      = tie_q;
        none_d     = none_q;
        cur_cnt_s  = cnt_s[idx_q];
        nb_s       = best_q;
        nbi_s      = best_idx_q;
        nt_s       = tie_run_q;

        // Argmax candidate for the neuron at idx_q; the first neuron seeds it.
        if (idx_q == '0) begin
            nb_s  = cur_cnt_s;
            nbi_s = '0;
            nt_s  = 1'b0;
        end else if (cur_cnt_s > best_q) begin
            nb_s  = cur_cnt_s;
            nbi_s = idx_q;
            nt_s  = 1'b0;
        end else if (cur_cnt_s == best_q) begin
            nt_s  = 1'b1;
        end else begin
            nt_s  = tie_run_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_COUNT;
                tstep_d = '0;
            end
            ST_COUNT: begin
                if (tstep_q == TS_W'(TSTEPS - 1)) begin
                    state_d = ST_DECIDE;
                    idx_d   = '0;
                end else begin
                    tstep_d = tstep_q + TS_W'(1);
                end
            end
            ST_DECIDE: begin
                best_d     = nb_s;
                best_idx_d = nbi_s;
                tie_run_d  = nt_s;
                if (idx_q == CLS_W'(OUTPUTS - 1)) begin
                    state_d = ST_HOLD;
                    none_d  = (nb_s == '0);
                    if (nb_s == '0) begin
                        class_d = '0;
                        tie_d   = 1'b0;
                    end else begin
                        class_d = nbi_s;
                        tie_d   = nt_s;
                    end
                end else begin
                    idx_d = idx_q + CLS_W'(1);
                end
            end
            ST_HOLD: begin
                // start_i is deliberately not looked at here.
                if (ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        re_d    = (state_d == ST_CLEAR);
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_HOLD);
    end

    // State, argmax scratch and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_IDLE;
            tstep_q    <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            tie_run_q  <= 1'b0;
            class_q    <= '0;
            tie_q      <= 1'b0;
            none_q     <= 1'b0;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tstep_q    <= tstep_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            tie_run_q  <= tie_run_d;
            class_q    <= class_d;
            tie_q      <= tie_d;
            none_q     <= none_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign re_o    = re_q;
    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign class_o = class_q;
    assign tie_o   = tie_q;
    assign none_o  = none_q;

`ifdef SPIKE_READOUT_COUNTS_EN
    logic [OUTPUTS*CNT_W-1:0] counts_s;

    // Pack the counter registers; they are frozen from DECIDE through HOLD.
    always_comb begin
        counts_s = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            counts_s[i*CNT_W +: CNT_W] = cnt_s[i];
        end
    end

    assign counts_o = counts_s;
`else
    // Best-index/tie scratch are fully consumed; nothing extra to expose.
`endif

endmodule

// File: tb/tb_spike_readout.sv
// Bench for spike_readout: a default instance (CNT_W=5) and a narrow
// instance (CNT_W=3) share stimulus. Expected results from a hand-computed
// table are pushed per window; a monitor pops and compares on each handshake.
module tb_spike_readout;

    typedef struct {
        logic [19:0] m0;
        logic [19:0] m1;
        int ac, at, an, a0, a1;
        int bc, bt, bn, b0, b1;
    } vec_t;

    typedef struct {
        int cls, tie, none, c0, c1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstb;
    logic       start_i;
    logic [1:0] spikes_i;
    logic       ready_i;
    logic       re_a, busy_a, valid_a, class_a, tie_a, none_a;
    logic       re_b, busy_b, valid_b, class_b, tie_b, none_b;
`ifdef SPIKE_READOUT_COUNTS_EN
    logic [9:0] counts_a;
    logic [5:0] counts_b;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vt [7];
    exp_t qa [$];
    exp_t qb [$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    spike_readout #(.OUTPUTS(2), .TSTEPS(20), .CNT_W(5), .CLS_W(1)) dut_a (
        .clk(clk), .rstb(rstb), .start_i(start_i), .spikes_i(spikes_i),
        .re_o(re_a), .busy_o(busy_a), .valid_o(valid_a), .ready_i(ready_i),
        .class_o(class_a), .tie_o(tie_a), .none_o(none_a)
`ifdef SPIKE_READOUT_COUNTS_EN
        , .counts_o(counts_a)
`endif
    );

    spike_readout #(.OUTPUTS(2), .TSTEPS(20), .CNT_W(3), .CLS_W(1)) dut_b (
        .clk(clk), .rstb(rstb), .start_i(start_i), .spikes_i(spikes_i),
        .re_o(re_b), .busy_o(busy_b), .valid_o(valid_b), .ready_i(ready_i),
        .class_o(class_b), .tie_o(tie_b), .none_o(none_b)
`ifdef SPIKE_READOUT_COUNTS_EN
        , .counts_o(counts_b)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_re_a"},    32'(re_a),    0);
        chk({tag, "_busy_a"},  32'(busy_a),  0);
        chk({tag, "_valid_a"}, 32'(valid_a), 0);
        chk({tag, "_class_a"}, 32'(class_a), 0);
        chk({tag, "_tie_a"},   32'(tie_a),   0);
        chk({tag, "_none_a"},  32'(none_a),  0);
        chk({tag, "_busy_b"},  32'(busy_b),  0);
        chk({tag, "_valid_b"}, 32'(valid_b), 0);
        chk({tag, "_class_b"}, 32'(class_b), 0);
        chk({tag, "_none_b"},  32'(none_b),  0);
`ifdef SPIKE_READOUT_COUNTS_EN
        chk({tag, "_counts_a"}, 32'(counts_a), 0);
`endif
    endtask

    // One window starting at a negedge in IDLE; spikes_i is 2'b11 outside
    // COUNT so stray spikes in CLEAR/DECIDE/HOLD would corrupt the counts.
    task automatic run_win(input int vi, input int hold_cyc, input bit pulse, input bit abort);
        int   cyc;
        exp_t e;
        start_i  = 1'b1;
        spikes_i = 2'b11;
        ready_i  = (hold_cyc == 0);
        if (!abort) begin
            e = '{vt[vi].ac, vt[vi].at, vt[vi].an, vt[vi].a0, vt[vi].a1};
            qa.push_back(e);
            e = '{vt[vi].bc, vt[vi].bt, vt[vi].bn, vt[vi].b0, vt[vi].b1};
            qb.push_back(e);
        end
        @(posedge clk);                       // edge k
        @(negedge clk);
        start_i = 1'b0;
        chk("re_in_clear", 32'(re_a), 1);
        chk("busy_in_clear", 32'(busy_a), 1);
        @(posedge clk);                       // edge k+1
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            spikes_i = {vt[vi].m1[t], vt[vi].m0[t]};
            start_i  = pulse && (t == 5);
            if (t == 0) begin
                chk("re_after_clear", 32'(re_a), 0);
            end
            if (abort && (t == 10)) begin
                rstb = 1'b0;
                #1;
                chk_zero("abort");
                @(negedge clk);
                rstb     = 1'b1;
                spikes_i = 2'b00;
                start_i  = 1'b0;
                return;
            end
            @(posedge clk);                   // edge k+2+t
        end
        @(negedge clk);
        spikes_i = 2'b11;
        start_i  = 1'b0;
        cyc = 21;
        while (!valid_a && (cyc < 60)) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 23);
        for (int i = 0; i < hold_cyc; i++) begin
            chk("hold_valid", 32'(valid_a), 1);
            chk("hold_class", 32'(class_a), vt[vi].ac);
            chk("hold_tie", 32'(tie_a), vt[vi].at);
            start_i = pulse && (i == 3);
            @(posedge clk);
            @(negedge clk);
        end
        start_i = pulse;                      // start alongside the handshake is ignored
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        chk("idle_busy", 32'(busy_a), 0);
        chk("idle_valid", 32'(valid_b), 0);
        chk("idle_class_kept", 32'(class_a), vt[vi].ac);
    endtask

    // Scoreboard monitor: compare on every accepted result.
    always @(negedge clk) begin
        #1;
        if (valid_a && ready_i) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_class", 32'(class_a), ea.cls);
                chk("a_tie", 32'(tie_a), ea.tie);
                chk("a_none", 32'(none_a), ea.none);
`ifdef SPIKE_READOUT_COUNTS_EN
                chk("a_cnt0", 32'(counts_a[4:0]), ea.c0);
                chk("a_cnt1", 32'(counts_a[9:5]), ea.c1);
`endif
            end
        end
        if (valid_b && ready_i) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_class", 32'(class_b), eb.cls);
                chk("b_tie", 32'(tie_b), eb.tie);
                chk("b_none", 32'(none_b), eb.none);
`ifdef SPIKE_READOUT_COUNTS_EN
                chk("b_cnt0", 32'(counts_b[2:0]), eb.c0);
                chk("b_cnt1", 32'(counts_b[5:3]), eb.c1);
`endif
            end
        end
    end

    initial begin
        //            m0          m1         ac at an a0 a1  bc bt bn b0 b1
        vt[0] = '{20'h0001F, 20'hFFF00, 1, 0, 0, 5, 12, 1, 0, 0, 5, 7};
        vt[1] = '{20'h0007F, 20'h0007F, 0, 1, 0, 7, 7,  0, 1, 0, 7, 7};
        vt[2] = '{20'h00000, 20'h00000, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0};
        vt[3] = '{20'h0000F, 20'hFFFFF, 1, 0, 0, 4, 20, 1, 0, 0, 4, 7};
        vt[4] = '{20'hFFFFF, 20'h00FFF, 0, 0, 0, 20, 12, 0, 1, 0, 7, 7};
        vt[5] = '{20'h00000, 20'h80000, 1, 0, 0, 0, 1,  1, 0, 0, 0, 1};
        vt[6] = '{20'h00001, 20'h00000, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0};

        rstb     = 1'b0;
        start_i  = 1'b0;
        spikes_i = 2'b00;
        ready_i  = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rstb = 1'b1;
        @(negedge clk);

        run_win(0, 0, 1'b0, 1'b0);
        run_win(1, 0, 1'b0, 1'b0);
        run_win(2, 0, 1'b0, 1'b0);
        run_win(4, 0, 1'b0, 1'b0);
        run_win(5, 0, 1'b0, 1'b0);
        run_win(6, 0, 1'b0, 1'b0);
        run_win(3, 10, 1'b1, 1'b0);   // backpressure with ignored starts
        run_win(4, 0, 1'b0, 1'b1);    // reset mid-window, result dropped
        run_win(6, 0, 1'b0, 1'b0);    // fresh window after abort

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
